// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline redirect control.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } bru_state_e;

    localparam int unsigned C_ADDR_W          = 32;
    localparam int unsigned C_FLUSH_DEPTH_MAX = 15;
    localparam int unsigned C_CNT_W           = 4;
    localparam int unsigned C_STAT_W          = 32;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_unit
// Description : Turns a MEM-stage taken branch into a fetch redirect plus
//               younger-stage flushes. Define BRANCH_REDIRECT_STATS_EN to add
//               taken/stall event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = C_ADDR_W,
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              redirect_ready_i,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              flush_exmem_o,
`ifdef BRANCH_REDIRECT_STATS_EN
    output logic [C_STAT_W-1:0] taken_cnt_o,
    output logic [C_STAT_W-1:0] stall_cnt_o,
`endif
    output logic              busy_o
);

    localparam int unsigned C_DEPTH_EFF =
        (FLUSH_DEPTH > C_FLUSH_DEPTH_MAX) ? C_FLUSH_DEPTH_MAX : FLUSH_DEPTH;
    localparam logic [C_CNT_W-1:0] C_DRAIN_LOAD =
        (C_DEPTH_EFF == 0) ? '0 : C_CNT_W'(C_DEPTH_EFF - 1);

    bru_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic                valid_q;
    logic                flush_ifid_q;
    logic                flush_old_q;
    logic                busy_q;

    // Branch decisions are only honoured in IDLE; anything else belongs to a
    // younger instruction that is already being squashed.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (br_taken_i) begin
                    state_d = REDIRECT;
                    pc_d    = br_target_i;
                end
            end
            REDIRECT: begin
                if (redirect_ready_i) begin
                    if (C_DEPTH_EFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = C_DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            flush_ifid_q <= 1'b0;
            flush_old_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            valid_q      <= (state_d == REDIRECT);
            flush_old_q  <= (state_d == REDIRECT);
            flush_ifid_q <= (state_d != IDLE);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign redirect_valid_o = valid_q;
    assign redirect_pc_o    = pc_q;
    assign flush_ifid_o     = flush_ifid_q;
    assign flush_idex_o     = flush_old_q;
    assign flush_exmem_o    = flush_old_q;
    assign busy_o           = busy_q;

`ifdef BRANCH_REDIRECT_STATS_EN
    generate
        if (1) begin : g_stats
            logic [C_STAT_W-1:0] taken_cnt_q;
            logic [C_STAT_W-1:0] stall_cnt_q;
            logic                taken_evt;
            logic                stall_evt;

            assign taken_evt = (state_q == IDLE) && br_taken_i;
            assign stall_evt = (state_q == REDIRECT) && !redirect_ready_i;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    taken_cnt_q <= '0;
                    stall_cnt_q <= '0;
                end else begin
                    if (taken_evt && (taken_cnt_q != '1)) begin
                        taken_cnt_q <= taken_cnt_q + C_STAT_W'(1);
                    end
                    if (stall_evt && (stall_cnt_q != '1)) begin
                        stall_cnt_q <= stall_cnt_q + C_STAT_W'(1);
                    end
                end
            end

            assign taken_cnt_o = taken_cnt_q;
            assign stall_cnt_o = stall_cnt_q;
        end
    endgenerate
`endif

endmodule : branch_redirect_unit
`default_nettype wire
